// File: rtl/mult_pkg.sv
// Shared types and constants for the pipelined multiplier and its sharing front-end.
// Pure declarations: no timing and no flow control of its own.
package mult_pkg;

    localparam int MULT_LAT = 5;
    localparam int OPND_W   = 32;
    localparam int PROD_W   = 64;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [PROD_W-1:0]   product;
    } res_entry_t;

    function automatic logic [MAX_ID_W-1:0] rr_next(input logic [MAX_ID_W-1:0] g, input int n);
        return (int'(g) == n - 1) ? '0 : g + 1'b1;
    endfunction

endpackage

// File: rtl/mult_res_fifo.sv
// Synchronous show-ahead FIFO; head is visible combinationally and reads zero when empty.
// Zero-cycle read latency; pushes while full and pops while empty are ignored.
module mult_res_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 67
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push_vld,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop_vld,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [W-1:0]             o_head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic [AW:0]  w_count;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_count    = w_count;
    assign o_empty    = (w_count == '0);
    assign o_full     = (w_count == (AW+1)'(DEPTH));
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push_vld && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop_vld && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is data-only; the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (i_push_vld && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/pipelined_mult.sv
// Unsigned 32x32 multiplier, 5 register stages, free-running.
// Latency 5 edges; no enable and no backpressure, so callers must budget space downstream.
module pipelined_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    import mult_pkg::*;

    logic [OPND_W-1:0] r_a, r_b;
    logic [31:0]       r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
    logic [PROD_W-1:0] r_sum, r_p4, r_p5;

    // 16-bit partial products, then a single recombination stage, then retiming.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_pp_ll <= '0;
            r_pp_lh <= '0;
            r_pp_hl <= '0;
            r_pp_hh <= '0;
            r_sum   <= '0;
            r_p4    <= '0;
            r_p5    <= '0;
        end else begin
            r_a     <= a;
            r_b     <= b;
            r_pp_ll <= 32'(r_a[15:0])  * 32'(r_b[15:0]);
            r_pp_lh <= 32'(r_a[15:0])  * 32'(r_b[31:16]);
            r_pp_hl <= 32'(r_a[31:16]) * 32'(r_b[15:0]);
            r_pp_hh <= 32'(r_a[31:16]) * 32'(r_b[31:16]);
            r_sum   <= {r_pp_hh, r_pp_ll} + (64'(r_pp_lh) << 16) + (64'(r_pp_hl) << 16);
            r_p4    <= r_sum;
            r_p5    <= r_p4;
        end
    end

    assign p = r_p5;

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin front-end sharing one pipelined multiplier among N_REQ requesters; ordered result FIFO.
// Result MULT_LAT+1 cycles after handshake; issue stalls once in-flight plus queued results reach FIFO_DEPTH.
module mult_share_ctrl #(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MULT_LAT   = mult_pkg::MULT_LAT,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*32-1:0]           req_a,
    input  logic [N_REQ*32-1:0]           req_b,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_id,
    output logic [63:0]                   res_p,
    output logic [$clog2(FIFO_DEPTH):0]   credits_used,
    output logic                          busy
);
    import mult_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ID_W-1:0]   r_rr_ptr;
    logic [CW-1:0]     r_credits;
    logic [MULT_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]   r_tag_id [MULT_LAT];

    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_found;
    logic              w_issue;
    logic              w_pop;
    logic [31:0]       w_op_a, w_op_b;
    logic [63:0]       w_mult_p;
    res_entry_t        w_push_dat, w_head;
    logic              w_fifo_full, w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;

    // Cyclic search starting at the pointer; the first valid requester wins.
    always_comb begin
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && req_valid[ID_W'(idx)]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'(idx);
            end
        end
    end

    // Gate on the registered count only: a same-cycle pop does not free a credit yet.
    assign w_issue   = !rst && w_found && (r_credits < CW'(FIFO_DEPTH));
    assign req_ready = w_issue ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_op_a    = w_issue ? req_a[32*int'(w_gnt_idx) +: 32] : '0;
    assign w_op_b    = w_issue ? req_b[32*int'(w_gnt_idx) +: 32] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= ID_W'(rr_next(MAX_ID_W'(w_gnt_idx), N_REQ));
        end
    end

    pipelined_mult u_mult (
        .clk (clk),
        .rst (rst),
        .a   (w_op_a),
        .b   (w_op_b),
        .p   (w_mult_p)
    );

    // Tag shift register mirrors the multiplier depth so the last stage lines up with p.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < MULT_LAT; i++) r_tag_id[i] <= '0;
        end else begin
            r_tag_vld   <= {r_tag_vld[MULT_LAT-2:0], w_issue};
            r_tag_id[0] <= w_gnt_idx;
            for (int i = 1; i < MULT_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
        end
    end

    always_comb begin
        w_push_dat         = '0;
        w_push_dat.id      = MAX_ID_W'(r_tag_id[MULT_LAT-1]);
        w_push_dat.product = w_mult_p;
    end

    mult_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(res_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (r_tag_vld[MULT_LAT-1]),
        .i_push_dat (w_push_dat),
        .i_pop_vld  (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count),
        .o_head_dat (w_head)
    );

    assign res_valid = !w_fifo_empty;
    assign res_id    = w_head.id[ID_W-1:0];
    assign res_p     = w_head.product;
    assign w_pop     = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign credits_used = r_credits;
    assign busy         = (r_credits != '0);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        r_tag_vld[MULT_LAT-1] |-> !w_fifo_full);
    a_credits_cover_fifo: assert property (@(posedge clk) disable iff (rst)
        r_credits >= w_fifo_count);
    a_id_fits: assert property (@(posedge clk) (w_head.id >> ID_W) == '0);

endmodule
